if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the word-addressed instruction memory. Holds the program counter and drives the IM word address. Selects the next PC from sequential, redirect (branch/jump target from D) or hold (stall). Captures the IM output into the IF/ID pipeline register consumed by decode.

---
 rtl/if_fetch_stage.sv | 61 ++++++
 tb/tb_if_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC, next-PC select and IF/ID register
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr,
    output logic [11:0] im_addr,
    output logic [31:0] pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        pc_fault
);

    localparam logic [11:0] ADDR_MASK    = 12'(IM_WORDS - 1);
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * IM_WORDS);

    logic [31:0] next_pc;
    logic [31:0] next_off;
    logic        misaligned;
    logic        out_of_window;

    // Word index wraps inside the window, so a runaway PC still fetches something.
    assign im_addr = 12'((pc - RESET_PC) >> 2) & ADDR_MASK;

    assign next_pc       = redirect ? {redirect_pc[31:2], 2'b00} : pc + 32'd4;
    assign misaligned    = redirect && (redirect_pc[1:0] != 2'b00);
    // Unsigned offset compare catches both below-base and past-end addresses.
    assign next_off      = next_pc - RESET_PC;
    assign out_of_window = next_off >= WINDOW_BYTES;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            instr_d  <= 32'h0;
            pc_d     <= 32'h0;
            valid_d  <= 1'b0;
            pc_fault <= 1'b0;
        end else if (!stall) begin
            pc   <= next_pc;
            pc_d <= pc;
            if (flush) begin
                instr_d <= 32'h0;
                valid_d <= 1'b0;
            end else begin
                instr_d <= instr;
                valid_d <= 1'b1;
            end
            if (misaligned || out_of_window) begin
                pc_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized bench for if_fetch_stage against a behavioural fetch model
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam longint      TWO32    = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [11:0] im_addr;
    logic [31:0] pc, instr_d, pc_d;
    logic        valid_d, pc_fault;

    logic [31:0] mem [0:IM_WORDS-1];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    longint      m_pc;
    logic [31:0] m_instr_d, m_pc_d;
    bit          m_valid, m_fault;

    if_fetch_stage #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
        .im_addr(im_addr), .pc(pc), .instr_d(instr_d), .pc_d(pc_d),
        .valid_d(valid_d), .pc_fault(pc_fault)
    );

    always #5 clk = ~clk;

    assign instr = mem[im_addr];

    function automatic longint model_word();
        return ((m_pc + TWO32 - longint'(RESET_PC)) % TWO32) / 4 % IM_WORDS;
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr_d = 32'h0;
        m_pc_d    = 32'h0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_edge(bit s, bit f, bit r, logic [31:0] rpc);
        longint np;
        longint lo, hi;
        if (s) return;
        lo = RESET_PC;
        hi = lo + 4 * IM_WORDS;
        np = r ? (longint'(rpc) / 4) * 4 : (m_pc + 4) % TWO32;
        m_instr_d = f ? 32'h0 : mem[model_word()];
        m_pc_d    = m_pc[31:0];
        m_valid   = !f;
        if ((r && (rpc % 4 != 0)) || np < lo || np >= hi) m_fault = 1'b1;
        m_pc = np;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",       pc,               m_pc[31:0]);
            chk("im_addr",  32'(im_addr),     32'(model_word()));
            chk("instr_d",  instr_d,          m_instr_d);
            chk("pc_d",     pc_d,             m_pc_d);
            chk("valid_d",  32'(valid_d),     32'(m_valid));
            chk("pc_fault", 32'(pc_fault),    32'(m_fault));
        end
    end

    task automatic step(bit s, bit f, bit r, logic [31:0] rpc);
        stall = s; flush = f; redirect = r; redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, f, r, rpc);
        @(negedge clk);
    endtask

    // Called right after a negedge: reset drops mid-cycle, released at the next negedge.
    task automatic async_reset_midcycle(bit check_now);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        if (check_now) begin
            chk("async_pc",    pc,           32'h3000);
            chk("async_valid", 32'(valid_d), 32'h0);
            chk("async_fault", 32'(pc_fault), 32'h0);
            chk("async_im",    32'(im_addr), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        int          sel;
        for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h3C01_0001;
        mem[1] = 32'h3421_0002;
        mem[2] = 32'h0000_0000;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc",      pc,            32'h3000);
        chk("rst_instr_d", instr_d,       32'h0);
        chk("rst_valid",   32'(valid_d),  32'h0);
        chk("rst_fault",   32'(pc_fault), 32'h0);
        model_reset();
        chk_en = 1'b1;
        rst_n  = 1'b1;

        step(0, 0, 0, 32'h0);
        chk("seq1_instr_d", instr_d,      32'h3C01_0001);
        chk("seq1_pc_d",    pc_d,         32'h3000);
        chk("seq1_pc",      pc,           32'h3004);
        chk("seq1_im",      32'(im_addr), 32'h1);
        step(0, 0, 0, 32'h0);
        chk("seq2_pc",      pc,           32'h3008);

        step(1, 0, 1, 32'h3020);
        step(1, 1, 1, 32'h3020);
        chk("stall_pc",      pc,      32'h3008);
        chk("stall_instr_d", instr_d, 32'h3421_0002);
        chk("stall_pc_d",    pc_d,    32'h3004);
        step(0, 0, 1, 32'h3020);
        chk("delay_pc",      pc,           32'h3020);
        chk("delay_instr_d", instr_d,      32'h0);
        chk("delay_pc_d",    pc_d,         32'h3008);
        chk("delay_valid",   32'(valid_d), 32'h1);
        chk("delay_im",      32'(im_addr), 32'h8);

        step(0, 0, 1, 32'h3010);
        step(0, 1, 0, 32'h0);
        chk("flush_instr_d", instr_d,      32'h0);
        chk("flush_valid",   32'(valid_d), 32'h0);
        chk("flush_pc_d",    pc_d,         32'h3010);
        chk("flush_pc",      pc,           32'h3014);

        step(0, 0, 1, 32'h3022);
        chk("mis_pc",    pc,            32'h3020);
        chk("mis_fault", 32'(pc_fault), 32'h1);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("sticky_fault", 32'(pc_fault), 32'h1);

        step(0, 0, 1, 32'h3040);
        async_reset_midcycle(1'b1);

        step(0, 0, 1, 32'h6FFC);
        chk("last_pc",    pc,            32'h6FFC);
        chk("last_fault", 32'(pc_fault), 32'h0);
        chk("last_im",    32'(im_addr),  32'hFFF);
        step(0, 0, 0, 32'h0);
        chk("wrap_pc",    pc,            32'h7000);
        chk("wrap_fault", 32'(pc_fault), 32'h1);
        chk("wrap_im",    32'(im_addr),  32'h0);

        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      rpc = RESET_PC + 4 * $urandom_range(0, IM_WORDS - 1);
            else if (sel < 85) rpc = RESET_PC + $urandom_range(0, 4 * IM_WORDS - 1);
            else               rpc = $urandom;
            if ($urandom_range(0, 99) == 0) async_reset_midcycle(1'b0);
            else step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 25, rpc);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
